regfile_ckpt: RTL and testbench

Parametrised successor of the architectural register file / rename map, sitting between the decoder (issue, operand lookup), the ROB (commit, operand forwarding) and the branch unit (checkpoint save/restore). It holds committed values and per-register ROB dependency tags. It serves NRD combinational read ports with ROB bypass. It keeps up to NCKPT rename-map snapshots, so a mispredict restores the map selectively instead of flushing all dependencies.

---
 rtl/rf_pkg.sv | 17 +
 rtl/rf_ckpt_bank.sv | 107 ++++++++++
 rtl/regfile_ckpt.sv | 113 +++++++++++
 tb/tb_regfile_ckpt.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths and map types for the checkpointed register file.
package rf_pkg;
  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int RW        = $clog2(NREG);
  localparam int ROB_WIDTH = 4;
  localparam int NRD       = 2;
  localparam int NCKPT     = 4;
  localparam int CW        = $clog2(NCKPT);

  typedef logic [ROB_WIDTH-1:0] rob_tag_t;

  typedef struct packed {
    logic     has_dep;
    rob_tag_t dep;
  } map_entry_t;
endpackage

// File: rtl/rf_ckpt_bank.sv
// Ring of rename-map snapshots. Live slots are [head, head+count); a commit
// clear is broadcast to every live slot so a restored map never waits on a
// producer that has already retired.
module rf_ckpt_bank import rf_pkg::*; #(
  parameter int NREG      = rf_pkg::NREG,
  parameter int ROB_WIDTH = rf_pkg::ROB_WIDTH,
  parameter int NCKPT     = rf_pkg::NCKPT,
  localparam int RW       = $clog2(NREG),
  localparam int CW       = $clog2(NCKPT)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdy,
  input  logic                      flush,
  input  logic                      commit_en,
  input  logic [RW-1:0]             commit_rd,
  input  logic [ROB_WIDTH-1:0]      commit_rob_id,
  input  logic                      save,
  input  logic [NREG-1:0]           save_has,
  input  logic [NREG*ROB_WIDTH-1:0] save_dep,
  input  logic                      rel,
  input  logic                      restore,
  input  logic [CW-1:0]             restore_id,
  output logic [CW-1:0]             tail,
  output logic                      full,
  output logic [NREG-1:0]           restore_has,
  output logic [NREG*ROB_WIDTH-1:0] restore_dep
);
  localparam logic [CW:0] FULL_CNT = (CW+1)'(NCKPT);

  logic [NREG-1:0]           snap_has [NCKPT];
  logic [NREG*ROB_WIDTH-1:0] snap_dep [NCKPT];
  logic [CW-1:0]             head, tail_q;
  logic [CW:0]               count;

  logic [NCKPT-1:0] hit;
  logic             save_en, rel_en;
  logic [CW-1:0]    head_nxt, tail_r, diff;
  logic [CW:0]      cnt_r;

  assign tail = tail_q;
  assign full = (count == FULL_CNT);

  // Which live slots hold the committing tag as their producer for commit_rd.
  always_comb begin
    logic [CW-1:0] off;
    off = '0;
    hit = '0;
    for (int s = 0; s < NCKPT; s++) begin
      off    = CW'(s) - head;
      hit[s] = ({1'b0, off} < count) && commit_en && snap_has[s][commit_rd] &&
               (snap_dep[s][commit_rd*ROB_WIDTH +: ROB_WIDTH] == commit_rob_id);
    end
  end

  // Snapshot selected for restore, with this cycle's commit clear folded in.
  always_comb begin
    restore_has = snap_has[restore_id];
    restore_dep = snap_dep[restore_id];
    if (commit_en && restore_has[commit_rd] &&
        restore_dep[commit_rd*ROB_WIDTH +: ROB_WIDTH] == commit_rob_id)
      restore_has[commit_rd] = 1'b0;
  end

  // Pointer arithmetic; a restore to the newest slot of a full ring stays full.
  always_comb begin
    save_en  = save && !full;
    rel_en   = rel && (count != '0);
    head_nxt = head + CW'(rel_en);
    tail_r   = restore_id + CW'(1);
    diff     = tail_r - head_nxt;
    cnt_r    = (diff == '0 && count == FULL_CNT && !rel_en) ? FULL_CNT : {1'b0, diff};
  end

  // Slot storage and ring pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head   <= '0;
      tail_q <= '0;
      count  <= '0;
      for (int s = 0; s < NCKPT; s++) begin
        snap_has[s] <= '0;
        snap_dep[s] <= '0;
      end
    end else if (rdy) begin
      for (int s = 0; s < NCKPT; s++)
        if (hit[s]) snap_has[s][commit_rd] <= 1'b0;
      if (flush) begin
        head   <= '0;
        tail_q <= '0;
        count  <= '0;
      end else if (restore) begin
        head   <= head_nxt;
        tail_q <= tail_r;
        count  <= cnt_r;
      end else begin
        if (save_en) begin
          snap_has[tail_q] <= save_has;
          snap_dep[tail_q] <= save_dep;
        end
        head   <= head_nxt;
        tail_q <= tail_q + CW'(save_en);
        count  <= count + (CW+1)'(save_en) - (CW+1)'(rel_en);
      end
    end
  end
endmodule

// File: rtl/regfile_ckpt.sv
// Architectural register file with rename map, ROB-bypassed read ports and
// a checkpoint ring for selective mispredict recovery.
module regfile_ckpt import rf_pkg::*; #(
  parameter int XLEN      = rf_pkg::XLEN,
  parameter int NREG      = rf_pkg::NREG,
  parameter int ROB_WIDTH = rf_pkg::ROB_WIDTH,
  parameter int NRD       = rf_pkg::NRD,
  parameter int NCKPT     = rf_pkg::NCKPT,
  localparam int RW       = $clog2(NREG),
  localparam int CW       = $clog2(NCKPT)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     flush_in,
  input  logic                     commit_valid,
  input  logic [RW-1:0]            commit_rd,
  input  logic [XLEN-1:0]          commit_val,
  input  logic [ROB_WIDTH-1:0]     commit_rob_id,
  input  logic                     issue_valid,
  input  logic [RW-1:0]            issue_rd,
  input  logic [ROB_WIDTH-1:0]     issue_rob_id,
  input  logic [NRD*RW-1:0]        rd_addr,
  output logic [NRD*XLEN-1:0]      rd_val,
  output logic [NRD-1:0]           rd_has_dep,
  output logic [NRD*ROB_WIDTH-1:0] rd_dep,
  output logic [NRD*ROB_WIDTH-1:0] rob_qry_id,
  input  logic [NRD-1:0]           rob_qry_ready,
  input  logic [NRD*XLEN-1:0]      rob_qry_val,
  input  logic                     ckpt_save,
  output logic [CW-1:0]            ckpt_id,
  output logic                     ckpt_full,
  input  logic                     ckpt_release,
  input  logic                     ckpt_restore,
  input  logic [CW-1:0]            ckpt_restore_id
);
  logic [XLEN-1:0]           val [NREG];
  logic [NREG-1:0]           has_dep;
  logic [NREG*ROB_WIDTH-1:0] dep;

  logic                      commit_en, issue_en, clr_live;
  logic [NREG-1:0]           save_has, rest_has;
  logic [NREG*ROB_WIDTH-1:0] rest_dep;

  // x0 never takes a value or a dependency.
  assign commit_en = commit_valid && (commit_rd != '0);
  assign issue_en  = issue_valid && (issue_rd != '0);
  assign clr_live  = commit_en && has_dep[commit_rd] &&
                     (dep[commit_rd*ROB_WIDTH +: ROB_WIDTH] == commit_rob_id);

  // Snapshot image: map after this cycle's commit clear, before its issue.
  always_comb begin
    save_has = has_dep;
    if (clr_live) save_has[commit_rd] = 1'b0;
  end

  rf_ckpt_bank #(.NREG(NREG), .ROB_WIDTH(ROB_WIDTH), .NCKPT(NCKPT)) u_bank (
    .clk           (clk_in),
    .rst_n         (rst_n_in),
    .rdy           (rdy_in),
    .flush         (flush_in),
    .commit_en     (commit_en),
    .commit_rd     (commit_rd),
    .commit_rob_id (commit_rob_id),
    .save          (ckpt_save),
    .save_has      (save_has),
    .save_dep      (dep),
    .rel           (ckpt_release),
    .restore       (ckpt_restore),
    .restore_id    (ckpt_restore_id),
    .tail          (ckpt_id),
    .full          (ckpt_full),
    .restore_has   (rest_has),
    .restore_dep   (rest_dep)
  );

  // Committed values and live map; commit writes land even on flush/restore.
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < NREG; r++) val[r] <= '0;
      has_dep <= '0;
      dep     <= '0;
    end else if (rdy_in) begin
      if (commit_en) val[commit_rd] <= commit_val;
      if (flush_in) begin
        has_dep <= '0;
        dep     <= '0;
      end else if (ckpt_restore) begin
        has_dep <= rest_has;
        dep     <= rest_dep;
      end else begin
        if (clr_live) has_dep[commit_rd] <= 1'b0;
        if (issue_en) begin
          has_dep[issue_rd]                        <= 1'b1;
          dep[issue_rd*ROB_WIDTH +: ROB_WIDTH]     <= issue_rob_id;
        end
      end
    end
  end

  // Read ports: committed value, else ROB forward, else wait on the tag.
  for (genvar p = 0; p < NRD; p++) begin : g_rd
    logic [RW-1:0] a;
    logic          has;
    assign a   = rd_addr[p*RW +: RW];
    assign has = has_dep[a];
    assign rd_val[p*XLEN +: XLEN] = !has              ? val[a] :
                                    rob_qry_ready[p]  ? rob_qry_val[p*XLEN +: XLEN] : '0;
    assign rd_has_dep[p]                        = has & ~rob_qry_ready[p];
    assign rd_dep[p*ROB_WIDTH +: ROB_WIDTH]     = dep[a*ROB_WIDTH +: ROB_WIDTH];
    assign rob_qry_id[p*ROB_WIDTH +: ROB_WIDTH] = dep[a*ROB_WIDTH +: ROB_WIDTH];
  end
endmodule

// File: tb/tb_regfile_ckpt.sv
// Directed plus randomized bench for regfile_ckpt against a map/queue model.
module tb_regfile_ckpt;
  logic        clk_in = 0, rst_n_in, rdy_in, flush_in;
  logic        commit_valid, issue_valid;
  logic [4:0]  commit_rd, issue_rd;
  logic [31:0] commit_val;
  logic [3:0]  commit_rob_id, issue_rob_id;
  logic [9:0]  rd_addr;
  logic [63:0] rd_val, rob_qry_val;
  logic [1:0]  rd_has_dep, rob_qry_ready;
  logic [7:0]  rd_dep, rob_qry_id;
  logic        ckpt_save, ckpt_full, ckpt_release, ckpt_restore;
  logic [1:0]  ckpt_id, ckpt_restore_id;

  regfile_ckpt dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .commit_valid(commit_valid), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_rob_id(commit_rob_id), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .issue_rob_id(issue_rob_id), .rd_addr(rd_addr), .rd_val(rd_val),
    .rd_has_dep(rd_has_dep), .rd_dep(rd_dep), .rob_qry_id(rob_qry_id),
    .rob_qry_ready(rob_qry_ready), .rob_qry_val(rob_qry_val), .ckpt_save(ckpt_save),
    .ckpt_id(ckpt_id), .ckpt_full(ckpt_full), .ckpt_release(ckpt_release),
    .ckpt_restore(ckpt_restore), .ckpt_restore_id(ckpt_restore_id)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: a map value plus an age-ordered list of snapshots.
  typedef struct packed {
    logic [31:0]      has;
    logic [31:0][3:0] dep;
  } map_t;
  map_t        live;
  map_t        q[$];
  int          base;
  logic [31:0] mval [32];
  int          vectors = 0, miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    live = '0;
    for (int r = 0; r < 32; r++) mval[r] = '0;
    q.delete();
    base = 0;
  endtask

  task automatic model_update();
    int n0, k;
    if (!rst_n_in) begin model_reset(); return; end
    if (!rdy_in) return;
    if (commit_valid && commit_rd != 0) begin
      mval[commit_rd] = commit_val;
      if (live.has[commit_rd] && live.dep[commit_rd] == commit_rob_id) live.has[commit_rd] = 0;
      foreach (q[i])
        if (q[i].has[commit_rd] && q[i].dep[commit_rd] == commit_rob_id) q[i].has[commit_rd] = 0;
    end
    if (flush_in) begin
      live = '0; q.delete(); base = 0;
    end else if (ckpt_restore) begin
      k = (int'(ckpt_restore_id) - base + 4) % 4;
      while (q.size() > k + 1) void'(q.pop_back());
      live = q[k];
      if (ckpt_release && q.size() > 0) begin void'(q.pop_front()); base = (base + 1) % 4; end
    end else begin
      n0 = q.size();
      if (ckpt_save && n0 < 4) q.push_back(live);
      if (ckpt_release && n0 > 0) begin void'(q.pop_front()); base = (base + 1) % 4; end
      if (issue_valid && issue_rd != 0) begin
        live.has[issue_rd] = 1'b1;
        live.dep[issue_rd] = issue_rob_id;
      end
    end
  endtask

  task automatic check_outputs();
    logic [4:0]  a;
    logic        h;
    logic [31:0] ev;
    for (int p = 0; p < 2; p++) begin
      a  = rd_addr[p*5 +: 5];
      h  = live.has[a];
      ev = !h ? mval[a] : rob_qry_ready[p] ? rob_qry_val[p*32 +: 32] : 32'd0;
      chk("rd_val",     64'(rd_val[p*32 +: 32]), 64'(ev));
      chk("rd_has_dep", 64'(rd_has_dep[p]),      64'(h & ~rob_qry_ready[p]));
      chk("rd_dep",     64'(rd_dep[p*4 +: 4]),   64'(live.dep[a]));
      chk("rob_qry_id", 64'(rob_qry_id[p*4 +: 4]), 64'(live.dep[a]));
    end
    chk("ckpt_id",   64'(ckpt_id),   64'((base + q.size()) % 4));
    chk("ckpt_full", 64'(ckpt_full), 64'(q.size() == 4));
  endtask

  // Inputs are set at the falling edge; outputs checked before the rising edge.
  task automatic step();
    #1 check_outputs();
    @(posedge clk_in);
    #1 model_update();
    @(negedge clk_in);
  endtask

  task automatic idle();
    rst_n_in = 1; rdy_in = 1; flush_in = 0;
    commit_valid = 0; commit_rd = 0; commit_val = 0; commit_rob_id = 0;
    issue_valid = 0; issue_rd = 0; issue_rob_id = 0;
    rob_qry_ready = 0; rob_qry_val = 0;
    ckpt_save = 0; ckpt_release = 0; ckpt_restore = 0; ckpt_restore_id = 0;
  endtask

  task automatic rd0(input logic [4:0] a);
    rd_addr = {5'd0, a};
  endtask

  task automatic randomize_inputs();
    idle();
    rdy_in        = ($urandom % 10) != 0;
    flush_in      = ($urandom % 40) == 0;
    commit_valid  = 1'($urandom % 2);
    commit_rd     = 5'($urandom % 8);
    commit_rob_id = ($urandom % 2) ? live.dep[commit_rd] : 4'($urandom % 16);
    commit_val    = $urandom;
    issue_valid   = 1'($urandom % 2);
    issue_rd      = 5'($urandom % 8);
    issue_rob_id  = 4'($urandom % 16);
    ckpt_save     = ($urandom % 4) == 0;
    ckpt_release  = ($urandom % 5) == 0;
    if (q.size() > 0 && ($urandom % 8) == 0) begin
      ckpt_restore    = 1;
      ckpt_restore_id = 2'((base + int'($urandom % q.size())) % 4);
    end
    rd_addr       = {5'($urandom % 8), 5'($urandom % 8)};
    rob_qry_ready = 2'($urandom % 4);
    rob_qry_val   = {$urandom, $urandom};
  endtask

  initial begin
    idle();
    rd_addr  = '0;
    rst_n_in = 0;
    model_reset();
    @(posedge clk_in); @(posedge clk_in);
    @(negedge clk_in);
    rst_n_in = 1;

    // Reset state.
    rd0(5);
    #1 chk("reset_val", 64'(rd_val[31:0]), 64'd0);
    chk("reset_has", 64'(rd_has_dep[0]), 64'd0);
    chk("reset_id", 64'(ckpt_id), 64'd0);
    chk("reset_full", 64'(ckpt_full), 64'd0);
    step();

    // Issue x5 tag 3, then forward from the ROB.
    issue_valid = 1; issue_rd = 5; issue_rob_id = 3; step();
    idle(); rd0(5);
    #1 chk("x5_has", 64'(rd_has_dep[0]), 64'd1);
    chk("x5_dep", 64'(rd_dep[3:0]), 64'd3);
    step();
    rob_qry_ready = 2'b01; rob_qry_val = 64'h0AB;
    #1 chk("x5_fwd_val", 64'(rd_val[31:0]), 64'h0AB);
    chk("x5_fwd_has", 64'(rd_has_dep[0]), 64'd0);
    step();

    // Same-cycle issue and stale commit on x7.
    idle(); issue_valid = 1; issue_rd = 7; issue_rob_id = 2;
    commit_valid = 1; commit_rd = 7; commit_rob_id = 1; commit_val = 9; step();
    idle(); rd0(7);
    #1 chk("x7_has", 64'(rd_has_dep[0]), 64'd1);
    chk("x7_dep", 64'(rd_dep[3:0]), 64'd2);
    step();
    commit_valid = 1; commit_rd = 7; commit_rob_id = 2; commit_val = 4; step();
    idle(); rd0(7);
    #1 chk("x7_clr_has", 64'(rd_has_dep[0]), 64'd0);
    chk("x7_val", 64'(rd_val[31:0]), 64'd4);
    step();

    // Checkpoint save/restore on x1, commit clear reaching a snapshot.
    issue_valid = 1; issue_rd = 1; issue_rob_id = 1; step();
    idle(); ckpt_save = 1; rd0(1);
    #1 chk("save_id0", 64'(ckpt_id), 64'd0);
    step();
    idle(); issue_valid = 1; issue_rd = 1; issue_rob_id = 5; step();
    idle(); rd0(1);
    #1 chk("x1_dep5", 64'(rd_dep[3:0]), 64'd5);
    ckpt_restore = 1; ckpt_restore_id = 0; step();
    idle(); rd0(1);
    #1 chk("x1_rest_dep", 64'(rd_dep[3:0]), 64'd1);
    chk("x1_rest_has", 64'(rd_has_dep[0]), 64'd1);
    chk("rest_id", 64'(ckpt_id), 64'd1);
    ckpt_save = 1; step();
    idle(); issue_valid = 1; issue_rd = 1; issue_rob_id = 6; step();
    idle(); commit_valid = 1; commit_rd = 1; commit_rob_id = 1; commit_val = 32'h11; step();
    idle(); ckpt_restore = 1; ckpt_restore_id = 1; step();
    idle(); rd0(1);
    #1 chk("snap_clr_has", 64'(rd_has_dep[0]), 64'd0);
    chk("snap_clr_dep", 64'(rd_dep[3:0]), 64'd1);
    chk("snap_clr_val", 64'(rd_val[31:0]), 64'h11);
    step();

    // Fill the ring, overflow, release, wrap.
    flush_in = 1; step();
    idle();
    for (int i = 0; i < 4; i++) begin ckpt_save = 1; step(); end
    #1 chk("full4", 64'(ckpt_full), 64'd1);
    step();
    #1 chk("full5_id", 64'(ckpt_id), 64'd0);
    idle(); ckpt_release = 1; step();
    idle();
    #1 chk("rel_full", 64'(ckpt_full), 64'd0);
    chk("wrap_id", 64'(ckpt_id), 64'd0);
    ckpt_save = 1; step();
    idle();
    #1 chk("wrap_id1", 64'(ckpt_id), 64'd1);

    // Flush with live deps and checkpoints, then a paused cycle.
    issue_valid = 1; issue_rd = 3; issue_rob_id = 7; step();
    idle(); flush_in = 1; step();
    idle(); rd0(3);
    #1 chk("flush_has", 64'(rd_has_dep[0]), 64'd0);
    chk("flush_id", 64'(ckpt_id), 64'd0);
    chk("flush_full", 64'(ckpt_full), 64'd0);
    rdy_in = 0; issue_valid = 1; issue_rd = 4; issue_rob_id = 2; ckpt_save = 1; step();
    idle(); rd0(4);
    #1 chk("pause_has", 64'(rd_has_dep[0]), 64'd0);
    chk("pause_id", 64'(ckpt_id), 64'd0);
    step();

    for (int i = 0; i < 600; i++) begin randomize_inputs(); step(); end

    // Reset in the middle of live checkpoints.
    idle();
    for (int i = 0; i < 3; i++) begin ckpt_save = 1; issue_valid = 1; issue_rd = 5'(i + 2); step(); end
    idle(); rst_n_in = 0; issue_valid = 1; issue_rd = 2; step();
    idle(); rd0(2);
    #1 chk("mid_rst_id", 64'(ckpt_id), 64'd0);
    chk("mid_rst_has", 64'(rd_has_dep[0]), 64'd0);
    step();
    for (int i = 0; i < 100; i++) begin randomize_inputs(); step(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
